// File: rtl/udp_eth_tx_mux_pkg.sv
// rtl/udp_eth_tx_mux_pkg.sv - shared types and defaults for the UDP/Ethernet TX channel mux
package udp_eth_tx_mux_pkg;

    localparam int CHANNELS_DEF       = 4;
    localparam int CH_ID_WIDTH_DEF    = 2;
    localparam int DATA_WIDTH_DEF     = 256;
    localparam int KEEP_WIDTH_DEF     = DATA_WIDTH_DEF / 8;
    localparam int UDP_LEN_WIDTH_DEF  = 16;
    localparam int IP_ADDR_WIDTH_DEF  = 32;
    localparam int UDP_PORT_WIDTH_DEF = 16;
    localparam int MAC_ADDR_WIDTH_DEF = 48;
    localparam int ETH_TYPE_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_META,
        ST_DATA
    } state_t;

    typedef struct packed {
        logic [IP_ADDR_WIDTH_DEF-1:0]  ip_addr;
        logic [UDP_PORT_WIDTH_DEF-1:0] dst_port;
        logic [UDP_PORT_WIDTH_DEF-1:0] src_port;
        logic [UDP_LEN_WIDTH_DEF-1:0]  data_len;
    } udp_meta_t;

    typedef struct packed {
        logic [MAC_ADDR_WIDTH_DEF-1:0] mac_addr;
        logic [ETH_TYPE_WIDTH_DEF-1:0] eth_type;
    } mac_meta_t;

    function automatic int next_ch(input int ch, input int channels);
        return (ch + 1 >= channels) ? 0 : ch + 1;
    endfunction

endpackage

// File: rtl/udp_eth_rr_arbiter.sv
// rtl/udp_eth_rr_arbiter.sv - combinational round-robin pick starting at ptr
module udp_eth_rr_arbiter #(
    parameter int CHANNELS    = 4,
    parameter int CH_ID_WIDTH = 2
) (
    input  logic [CHANNELS-1:0]    req,
    input  logic [CH_ID_WIDTH-1:0] ptr,
    output logic [CHANNELS-1:0]    grant,
    output logic [CH_ID_WIDTH-1:0] grant_idx,
    output logic                   grant_any
);

    // Bit k of req_rot is channel (ptr + k) mod CHANNELS.
    logic [CHANNELS-1:0] req_rot;
    int                  offset;
    int                  idx;

    assign req_rot = CHANNELS'({req, req} >> ptr);

    always_comb begin
        grant_any = 1'b0;
        offset    = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_any = 1'b1;
                offset    = k;
            end
        end
        idx = int'(ptr) + offset;
        if (idx >= CHANNELS) begin
            idx = idx - CHANNELS;
        end
        grant_idx = CH_ID_WIDTH'(idx);
        grant     = grant_any ? (CHANNELS'(1) << idx) : '0;
    end

endmodule

// File: rtl/udp_eth_tx_mux.sv
// rtl/udp_eth_tx_mux.sv - packet-atomic round-robin mux of N UDP/MAC meta + data channels
module udp_eth_tx_mux
    import udp_eth_tx_mux_pkg::*;
#(
    parameter int CHANNELS       = CHANNELS_DEF,
    parameter int CH_ID_WIDTH    = CH_ID_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int KEEP_WIDTH     = KEEP_WIDTH_DEF,
    parameter int UDP_LEN_WIDTH  = UDP_LEN_WIDTH_DEF,
    parameter int IP_ADDR_WIDTH  = IP_ADDR_WIDTH_DEF,
    parameter int UDP_PORT_WIDTH = UDP_PORT_WIDTH_DEF,
    parameter int MAC_ADDR_WIDTH = MAC_ADDR_WIDTH_DEF,
    parameter int ETH_TYPE_WIDTH = ETH_TYPE_WIDTH_DEF
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [CHANNELS-1:0]                s_udp_meta_valid,
    output logic [CHANNELS-1:0]                s_udp_meta_ready,
    input  logic [CHANNELS*IP_ADDR_WIDTH-1:0]  s_udp_meta_ip_addr,
    input  logic [CHANNELS*UDP_PORT_WIDTH-1:0] s_udp_meta_dst_port,
    input  logic [CHANNELS*UDP_PORT_WIDTH-1:0] s_udp_meta_src_port,
    input  logic [CHANNELS*UDP_LEN_WIDTH-1:0]  s_udp_meta_data_len,
    input  logic [CHANNELS-1:0]                s_mac_meta_valid,
    output logic [CHANNELS-1:0]                s_mac_meta_ready,
    input  logic [CHANNELS*MAC_ADDR_WIDTH-1:0] s_mac_meta_mac_addr,
    input  logic [CHANNELS*ETH_TYPE_WIDTH-1:0] s_mac_meta_eth_type,
    input  logic [CHANNELS-1:0]                s_data_stream_tvalid,
    output logic [CHANNELS-1:0]                s_data_stream_tready,
    input  logic [CHANNELS-1:0]                s_data_stream_tfirst,
    input  logic [CHANNELS-1:0]                s_data_stream_tlast,
    input  logic [CHANNELS*DATA_WIDTH-1:0]     s_data_stream_tdata,
    input  logic [CHANNELS*KEEP_WIDTH-1:0]     s_data_stream_tkeep,
    output logic                               m_udp_meta_valid,
    input  logic                               m_udp_meta_ready,
    output logic [IP_ADDR_WIDTH-1:0]           m_udp_meta_ip_addr,
    output logic [UDP_PORT_WIDTH-1:0]          m_udp_meta_dst_port,
    output logic [UDP_PORT_WIDTH-1:0]          m_udp_meta_src_port,
    output logic [UDP_LEN_WIDTH-1:0]           m_udp_meta_data_len,
    output logic                               m_mac_meta_valid,
    input  logic                               m_mac_meta_ready,
    output logic [MAC_ADDR_WIDTH-1:0]          m_mac_meta_mac_addr,
    output logic [ETH_TYPE_WIDTH-1:0]          m_mac_meta_eth_type,
    output logic                               m_data_stream_tvalid,
    input  logic                               m_data_stream_tready,
    output logic [DATA_WIDTH-1:0]              m_data_stream_tdata,
    output logic [KEEP_WIDTH-1:0]              m_data_stream_tkeep,
    output logic                               m_data_stream_tfirst,
    output logic                               m_data_stream_tlast,
    output logic [CH_ID_WIDTH-1:0]             m_channel_id,
    output logic [CHANNELS-1:0]                frame_err
);

    state_t                   state_q;
    state_t                   state_d;
    logic [CH_ID_WIDTH-1:0]   rr_ptr;
    logic                     first_pending;
    logic                     udp_valid_d;
    logic                     mac_valid_d;
    logic                     capture;
    logic                     beat_hs;
    logic [CHANNELS-1:0]      eligible;
    logic [CHANNELS-1:0]      grant_oh;
    logic [CH_ID_WIDTH-1:0]   grant_idx;
    logic                     grant_any;
    logic [CHANNELS-1:0]      sel_oh;

    logic [IP_ADDR_WIDTH-1:0]  ip_a       [CHANNELS];
    logic [UDP_PORT_WIDTH-1:0] dst_a      [CHANNELS];
    logic [UDP_PORT_WIDTH-1:0] src_a      [CHANNELS];
    logic [UDP_LEN_WIDTH-1:0]  len_a      [CHANNELS];
    logic [MAC_ADDR_WIDTH-1:0] mac_a      [CHANNELS];
    logic [ETH_TYPE_WIDTH-1:0] type_a     [CHANNELS];
    logic [DATA_WIDTH-1:0]     tdata_a    [CHANNELS];
    logic [KEEP_WIDTH-1:0]     tkeep_a    [CHANNELS];

    genvar i;
    for (i = 0; i < CHANNELS; i++) begin : g_unpack
        assign ip_a[i]    = s_udp_meta_ip_addr[i*IP_ADDR_WIDTH +: IP_ADDR_WIDTH];
        assign dst_a[i]   = s_udp_meta_dst_port[i*UDP_PORT_WIDTH +: UDP_PORT_WIDTH];
        assign src_a[i]   = s_udp_meta_src_port[i*UDP_PORT_WIDTH +: UDP_PORT_WIDTH];
        assign len_a[i]   = s_udp_meta_data_len[i*UDP_LEN_WIDTH +: UDP_LEN_WIDTH];
        assign mac_a[i]   = s_mac_meta_mac_addr[i*MAC_ADDR_WIDTH +: MAC_ADDR_WIDTH];
        assign type_a[i]  = s_mac_meta_eth_type[i*ETH_TYPE_WIDTH +: ETH_TYPE_WIDTH];
        assign tdata_a[i] = s_data_stream_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign tkeep_a[i] = s_data_stream_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
    end

    // Only channels with both metas pending compete, so a half-presented packet never stalls the grant.
    assign eligible = s_udp_meta_valid & s_mac_meta_valid;

    udp_eth_rr_arbiter #(
        .CHANNELS    (CHANNELS),
        .CH_ID_WIDTH (CH_ID_WIDTH)
    ) u_arbiter (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sel_oh               = CHANNELS'(1) << m_channel_id;
    assign m_data_stream_tdata  = tdata_a[m_channel_id];
    assign m_data_stream_tkeep  = tkeep_a[m_channel_id];
    assign m_data_stream_tfirst = s_data_stream_tfirst[m_channel_id];
    assign m_data_stream_tlast  = s_data_stream_tlast[m_channel_id];

    always_comb begin
        state_d              = state_q;
        udp_valid_d          = m_udp_meta_valid;
        mac_valid_d          = m_mac_meta_valid;
        s_udp_meta_ready     = '0;
        s_mac_meta_ready     = '0;
        s_data_stream_tready = '0;
        m_data_stream_tvalid = 1'b0;
        capture              = 1'b0;
        beat_hs              = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Readies are gated by reset_n so they fall without waiting for a clock edge.
                if (grant_any && reset_n) begin
                    s_udp_meta_ready = grant_oh;
                    s_mac_meta_ready = grant_oh;
                    capture          = 1'b1;
                    udp_valid_d      = 1'b1;
                    mac_valid_d      = 1'b1;
                    state_d          = ST_META;
                end
            end
            ST_META: begin
                if (m_udp_meta_ready) begin
                    udp_valid_d = 1'b0;
                end
                if (m_mac_meta_ready) begin
                    mac_valid_d = 1'b0;
                end
                if (!udp_valid_d && !mac_valid_d) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                m_data_stream_tvalid = s_data_stream_tvalid[m_channel_id];
                if (m_data_stream_tready) begin
                    s_data_stream_tready = sel_oh;
                end
                beat_hs = s_data_stream_tvalid[m_channel_id] && m_data_stream_tready;
                if (beat_hs && s_data_stream_tlast[m_channel_id]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= ST_IDLE;
            rr_ptr              <= '0;
            m_channel_id        <= '0;
            frame_err           <= '0;
            first_pending       <= 1'b0;
            m_udp_meta_valid    <= 1'b0;
            m_mac_meta_valid    <= 1'b0;
            m_udp_meta_ip_addr  <= '0;
            m_udp_meta_dst_port <= '0;
            m_udp_meta_src_port <= '0;
            m_udp_meta_data_len <= '0;
            m_mac_meta_mac_addr <= '0;
            m_mac_meta_eth_type <= '0;
        end else begin
            state_q          <= state_d;
            m_udp_meta_valid <= udp_valid_d;
            m_mac_meta_valid <= mac_valid_d;
            if (capture) begin
                m_udp_meta_ip_addr  <= ip_a[grant_idx];
                m_udp_meta_dst_port <= dst_a[grant_idx];
                m_udp_meta_src_port <= src_a[grant_idx];
                m_udp_meta_data_len <= len_a[grant_idx];
                m_mac_meta_mac_addr <= mac_a[grant_idx];
                m_mac_meta_eth_type <= type_a[grant_idx];
                m_channel_id        <= grant_idx;
                first_pending       <= 1'b1;
            end
            if (beat_hs) begin
                first_pending <= 1'b0;
                // tfirst must be set exactly on the first accepted beat; the beat passes through either way.
                if (s_data_stream_tfirst[m_channel_id] != first_pending) begin
                    frame_err <= frame_err | sel_oh;
                end
                if (s_data_stream_tlast[m_channel_id]) begin
                    rr_ptr <= CH_ID_WIDTH'(next_ch(int'(m_channel_id), CHANNELS));
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_eth_tx_mux.sv
// tb/tb_udp_eth_tx_mux.sv - scoreboard bench for the UDP/Ethernet TX channel mux
module tb_udp_eth_tx_mux;
    import udp_eth_tx_mux_pkg::*;

    localparam int TIMEOUT = 200;

    typedef struct packed {
        logic [1:0] ch;
        udp_meta_t  meta;
    } exp_udp_t;

    typedef struct packed {
        logic [1:0] ch;
        mac_meta_t  meta;
    } exp_mac_t;

    typedef struct packed {
        logic [1:0]   ch;
        logic [255:0] data;
        logic [31:0]  keep;
        logic         first;
        logic         last;
    } exp_beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    s_udp_meta_valid = '0;
    logic [3:0]    s_udp_meta_ready;
    logic [127:0]  s_udp_meta_ip_addr = '0;
    logic [63:0]   s_udp_meta_dst_port = '0;
    logic [63:0]   s_udp_meta_src_port = '0;
    logic [63:0]   s_udp_meta_data_len = '0;
    logic [3:0]    s_mac_meta_valid = '0;
    logic [3:0]    s_mac_meta_ready;
    logic [191:0]  s_mac_meta_mac_addr = '0;
    logic [63:0]   s_mac_meta_eth_type = '0;
    logic [3:0]    s_data_stream_tvalid = '0;
    logic [3:0]    s_data_stream_tready;
    logic [3:0]    s_data_stream_tfirst = '0;
    logic [3:0]    s_data_stream_tlast = '0;
    logic [1023:0] s_data_stream_tdata = '0;
    logic [127:0]  s_data_stream_tkeep = '0;
    logic          m_udp_meta_valid;
    logic          m_udp_meta_ready = 1'b1;
    logic [31:0]   m_udp_meta_ip_addr;
    logic [15:0]   m_udp_meta_dst_port;
    logic [15:0]   m_udp_meta_src_port;
    logic [15:0]   m_udp_meta_data_len;
    logic          m_mac_meta_valid;
    logic          m_mac_meta_ready = 1'b1;
    logic [47:0]   m_mac_meta_mac_addr;
    logic [15:0]   m_mac_meta_eth_type;
    logic          m_data_stream_tvalid;
    logic          m_data_stream_tready = 1'b1;
    logic [255:0]  m_data_stream_tdata;
    logic [31:0]   m_data_stream_tkeep;
    logic          m_data_stream_tfirst;
    logic          m_data_stream_tlast;
    logic [1:0]    m_channel_id;
    logic [3:0]    frame_err;

    udp_eth_tx_mux dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .s_udp_meta_valid     (s_udp_meta_valid),
        .s_udp_meta_ready     (s_udp_meta_ready),
        .s_udp_meta_ip_addr   (s_udp_meta_ip_addr),
        .s_udp_meta_dst_port  (s_udp_meta_dst_port),
        .s_udp_meta_src_port  (s_udp_meta_src_port),
        .s_udp_meta_data_len  (s_udp_meta_data_len),
        .s_mac_meta_valid     (s_mac_meta_valid),
        .s_mac_meta_ready     (s_mac_meta_ready),
        .s_mac_meta_mac_addr  (s_mac_meta_mac_addr),
        .s_mac_meta_eth_type  (s_mac_meta_eth_type),
        .s_data_stream_tvalid (s_data_stream_tvalid),
        .s_data_stream_tready (s_data_stream_tready),
        .s_data_stream_tfirst (s_data_stream_tfirst),
        .s_data_stream_tlast  (s_data_stream_tlast),
        .s_data_stream_tdata  (s_data_stream_tdata),
        .s_data_stream_tkeep  (s_data_stream_tkeep),
        .m_udp_meta_valid     (m_udp_meta_valid),
        .m_udp_meta_ready     (m_udp_meta_ready),
        .m_udp_meta_ip_addr   (m_udp_meta_ip_addr),
        .m_udp_meta_dst_port  (m_udp_meta_dst_port),
        .m_udp_meta_src_port  (m_udp_meta_src_port),
        .m_udp_meta_data_len  (m_udp_meta_data_len),
        .m_mac_meta_valid     (m_mac_meta_valid),
        .m_mac_meta_ready     (m_mac_meta_ready),
        .m_mac_meta_mac_addr  (m_mac_meta_mac_addr),
        .m_mac_meta_eth_type  (m_mac_meta_eth_type),
        .m_data_stream_tvalid (m_data_stream_tvalid),
        .m_data_stream_tready (m_data_stream_tready),
        .m_data_stream_tdata  (m_data_stream_tdata),
        .m_data_stream_tkeep  (m_data_stream_tkeep),
        .m_data_stream_tfirst (m_data_stream_tfirst),
        .m_data_stream_tlast  (m_data_stream_tlast),
        .m_channel_id         (m_channel_id),
        .frame_err            (frame_err)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        failures = 0;
    int        cyc = 0;
    bit        abort = 1'b0;
    exp_udp_t  q_udp[$];
    exp_mac_t  q_mac[$];
    exp_beat_t q_beat[$];
    int        q_order[$];
    int        udp_cyc, mac_cyc, first_data_cyc;
    int        data_hs_count = 0;
    bit        want_first_data = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] beat_data(input int ch, input int tag, input int b);
        logic [31:0] w;
        w = 32'hD000_0000 | 32'(ch << 16) | 32'(tag << 8) | 32'(b);
        return {8{w}};
    endfunction

    // Pushes the packet's expectations, then drives metas and beats on channel ch.
    task automatic send_pkt(input int ch, input int tag, input int nbeats, input int bad_beat,
                            input logic [15:0] len);
        udp_meta_t u;
        mac_meta_t m;
        exp_udp_t  eu;
        exp_mac_t  em;
        exp_beat_t eb;
        int        n;
        u.ip_addr  = 32'hC0A8_0000 | 32'(tag << 8) | 32'(ch);
        u.dst_port = 16'h1000 + 16'(ch);
        u.src_port = 16'h2000 + 16'(tag);
        u.data_len = len;
        m.mac_addr = 48'h0200_0000_0000 | 48'(tag << 8) | 48'(ch);
        m.eth_type = 16'h0800;
        eu.ch = 2'(ch); eu.meta = u; q_udp.push_back(eu);
        em.ch = 2'(ch); em.meta = m; q_mac.push_back(em);
        for (int b = 0; b < nbeats; b++) begin
            eb.ch    = 2'(ch);
            eb.data  = beat_data(ch, tag, b);
            eb.keep  = (b == nbeats - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            eb.first = (b == 0) ^ (b == bad_beat);
            eb.last  = (b == nbeats - 1);
            q_beat.push_back(eb);
        end
        s_udp_meta_ip_addr[ch*32 +: 32]  = u.ip_addr;
        s_udp_meta_dst_port[ch*16 +: 16] = u.dst_port;
        s_udp_meta_src_port[ch*16 +: 16] = u.src_port;
        s_udp_meta_data_len[ch*16 +: 16] = u.data_len;
        s_mac_meta_mac_addr[ch*48 +: 48] = m.mac_addr;
        s_mac_meta_eth_type[ch*16 +: 16] = m.eth_type;
        s_udp_meta_valid[ch] = 1'b1;
        s_mac_meta_valid[ch] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s_udp_meta_ready[ch] && s_mac_meta_ready[ch]) && !abort && n < TIMEOUT);
        if (n >= TIMEOUT) chk($sformatf("meta_timeout_ch%0d", ch), 1, 0);
        if (abort || n >= TIMEOUT) begin
            s_udp_meta_valid[ch] = 1'b0;
            s_mac_meta_valid[ch] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_udp_meta_valid[ch] = 1'b0;
        s_mac_meta_valid[ch] = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            s_data_stream_tvalid[ch]           = 1'b1;
            s_data_stream_tdata[ch*256 +: 256] = beat_data(ch, tag, b);
            s_data_stream_tkeep[ch*32 +: 32]   = (b == nbeats - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            s_data_stream_tfirst[ch]           = (b == 0) ^ (b == bad_beat);
            s_data_stream_tlast[ch]            = (b == nbeats - 1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!s_data_stream_tready[ch] && !abort && n < TIMEOUT);
            if (n >= TIMEOUT) chk($sformatf("beat_timeout_ch%0d", ch), 1, 0);
            if (abort || n >= TIMEOUT) break;
            @(posedge clk);
            #1;
        end
        s_data_stream_tvalid[ch] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string tname);
        chk({tname, "_udp_left"}, q_udp.size(), 0);
        chk({tname, "_mac_left"}, q_mac.size(), 0);
        chk({tname, "_beat_left"}, q_beat.size(), 0);
        chk({tname, "_order_left"}, q_order.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    // Monitor: matches every output handshake against the per-channel expectations.
    initial begin
        int k;
        logic [3:0] sel;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (s_udp_meta_ready != '0 || s_mac_meta_ready != '0)
                    chk("meta_ready_pair", s_mac_meta_ready, s_udp_meta_ready);
                if (m_udp_meta_valid && m_udp_meta_ready) begin
                    udp_cyc = cyc;
                    want_first_data = 1'b1;
                    if (q_order.size() == 0) chk("grant_unexpected", 1, 0);
                    else chk("grant_order", m_channel_id, q_order.pop_front());
                    k = -1;
                    foreach (q_udp[j]) if (k < 0 && q_udp[j].ch == m_channel_id) k = j;
                    if (k < 0) chk("udp_unexpected", 1, 0);
                    else begin
                        chk("udp_ip", m_udp_meta_ip_addr, q_udp[k].meta.ip_addr);
                        chk("udp_dst", m_udp_meta_dst_port, q_udp[k].meta.dst_port);
                        chk("udp_src", m_udp_meta_src_port, q_udp[k].meta.src_port);
                        chk("udp_len", m_udp_meta_data_len, q_udp[k].meta.data_len);
                        q_udp.delete(k);
                    end
                end
                if (m_mac_meta_valid && m_mac_meta_ready) begin
                    mac_cyc = cyc;
                    k = -1;
                    foreach (q_mac[j]) if (k < 0 && q_mac[j].ch == m_channel_id) k = j;
                    if (k < 0) chk("mac_unexpected", 1, 0);
                    else begin
                        chk("mac_addr", m_mac_meta_mac_addr, q_mac[k].meta.mac_addr);
                        chk("mac_type", m_mac_meta_eth_type, q_mac[k].meta.eth_type);
                        q_mac.delete(k);
                    end
                end
                if (m_data_stream_tvalid && m_data_stream_tready) begin
                    data_hs_count++;
                    if (want_first_data) begin
                        first_data_cyc = cyc;
                        want_first_data = 1'b0;
                    end
                    sel = 4'b0001 << m_channel_id;
                    chk("other_tready", s_data_stream_tready & ~sel, 0);
                    k = -1;
                    foreach (q_beat[j]) if (k < 0 && q_beat[j].ch == m_channel_id) k = j;
                    if (k < 0) chk("beat_unexpected", 1, 0);
                    else begin
                        chk("beat_data", m_data_stream_tdata, q_beat[k].data);
                        chk("beat_keep", m_data_stream_tkeep, q_beat[k].keep);
                        chk("beat_first", m_data_stream_tfirst, q_beat[k].first);
                        chk("beat_last", m_data_stream_tlast, q_beat[k].last);
                        q_beat.delete(k);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int n;
        int hs0;
        bit pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        // Reset state, with every meta valid raised to show readies stay low.
        s_udp_meta_valid = 4'hF;
        s_mac_meta_valid = 4'hF;
        idle(3);
        @(negedge clk);
        chk("rst_udp_valid", m_udp_meta_valid, 0);
        chk("rst_mac_valid", m_mac_meta_valid, 0);
        chk("rst_tvalid", m_data_stream_tvalid, 0);
        chk("rst_udp_ready", s_udp_meta_ready, 0);
        chk("rst_mac_ready", s_mac_meta_ready, 0);
        chk("rst_tready", s_data_stream_tready, 0);
        chk("rst_channel_id", m_channel_id, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_ip_reg", m_udp_meta_ip_addr, 0);
        chk("rst_mac_reg", m_mac_meta_mac_addr, 0);
        s_udp_meta_valid = '0;
        s_mac_meta_valid = '0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        // Single packet on ch2; ch1 offers only its UDP meta and must be ignored.
        s_udp_meta_valid[1] = 1'b1;
        q_order.push_back(2);
        send_pkt(2, 0, 2, -1, 16'd64);
        idle(3);
        chk("t1_channel_id", m_channel_id, 2);
        chk("t1_frame_err", frame_err, 0);
        s_udp_meta_valid[1] = 1'b0;
        check_drained("t1");

        // Contention from rr_ptr=0: grant order 0,1,2,3,0.
        do_reset();
        q_order.push_back(0); q_order.push_back(1); q_order.push_back(2);
        q_order.push_back(3); q_order.push_back(0);
        fork
            begin
                send_pkt(0, 1, 1, -1, 16'd32);
                send_pkt(0, 5, 1, -1, 16'd32);
            end
            send_pkt(1, 2, 1, -1, 16'd32);
            send_pkt(2, 3, 1, -1, 16'd32);
            send_pkt(3, 4, 1, -1, 16'd32);
        join
        idle(3);
        check_drained("t2");

        // Meta skew: UDP meta ready held low for 5 META cycles.
        m_udp_meta_ready = 1'b0;
        q_order.push_back(1);
        c1 = 0;
        fork
            send_pkt(1, 6, 2, -1, 16'd64);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!m_udp_meta_valid && n < TIMEOUT);
                c1 = cyc;
                repeat (5) @(posedge clk);
                #1 m_udp_meta_ready = 1'b1;
            end
        join
        idle(3);
        chk("skew_mac_cycle", mac_cyc, c1);
        chk("skew_udp_cycle", udp_cyc, c1 + 5);
        chk("skew_data_cycle", first_data_cyc, c1 + 6);
        check_drained("t3");

        // Backpressure: m_tready pattern 1,0,0,1 during a 4-beat packet on ch1.
        hs0 = data_hs_count;
        q_order.push_back(1);
        fork
            send_pkt(1, 7, 4, -1, 16'd128);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!m_data_stream_tvalid && n < TIMEOUT);
                for (int k = 0; k < 12; k++) begin
                    m_data_stream_tready = pat[k % 4];
                    @(posedge clk);
                    #1;
                end
                m_data_stream_tready = 1'b1;
            end
        join
        idle(3);
        chk("bp_beat_count", data_hs_count - hs0, 4);
        check_drained("t4");

        // Framing error on ch3 beat 2; ch0 and ch1 wait, next grant after ch3 is ch0.
        q_order.push_back(3); q_order.push_back(0); q_order.push_back(1);
        fork
            send_pkt(3, 8, 3, 1, 16'd96);
            send_pkt(0, 9, 1, -1, 16'd32);
            send_pkt(1, 10, 1, -1, 16'd32);
        join
        idle(3);
        chk("t5_frame_err", frame_err, 4'b1000);
        check_drained("t5");

        // Reset pulsed during beat 2 of a ch2 packet.
        q_order.push_back(2);
        fork
            send_pkt(2, 11, 3, -1, 16'd96);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(m_data_stream_tvalid && !m_data_stream_tfirst) && n < TIMEOUT);
                chk("t6_mid_packet", m_data_stream_tvalid, 1);
                #2 reset_n = 1'b0;
                #1;
                chk("t6_async_tvalid", m_data_stream_tvalid, 0);
                chk("t6_async_udp_valid", m_udp_meta_valid, 0);
                chk("t6_async_mac_valid", m_mac_meta_valid, 0);
                chk("t6_async_tready", s_data_stream_tready, 0);
                chk("t6_async_meta_ready", {s_udp_meta_ready, s_mac_meta_ready}, 0);
                abort = 1'b1;
            end
        join
        idle(2);
        q_udp.delete(); q_mac.delete(); q_beat.delete(); q_order.delete();
        s_data_stream_tvalid = '0;
        reset_n = 1'b1;
        abort = 1'b0;
        idle(1);
        chk("t6_channel_id", m_channel_id, 0);
        chk("t6_frame_err", frame_err, 0);

        // After reset rr_ptr=0: ch0 (bad first beat), then ch1, then ch3.
        q_order.push_back(0); q_order.push_back(1); q_order.push_back(3);
        fork
            send_pkt(3, 12, 1, -1, 16'd32);
            send_pkt(1, 13, 1, -1, 16'd32);
            send_pkt(0, 14, 2, 0, 16'd64);
        join
        idle(3);
        chk("t7_frame_err", frame_err, 4'b0001);
        check_drained("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
